// File: rtl/serial_parallel_aligner.sv
// Serial-to-parallel deserializer that finds COM symbols at any bit offset and locks word alignment.
// Latency: one register stage, so outputs update immediately after the edge that samples a word's last bit.
// Backpressure: none; the lane runs at bit rate and each word is offered for one cycle with valid_out.
//
// Ports:
//   clk_32f   - bit-rate clock, all state updates on the rising edge
//   reset     - asynchronous active-low reset
//   data_in   - serial input, MSB of each word first
//   data_out  - last completed word seen while locked (registered)
//   valid_out - one-cycle pulse: data_out holds a new non-COM word
//   com_det   - one-cycle pulse: an aligned COM just completed
//   locked    - high while word alignment is locked
module serial_parallel_aligner #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COM        = 8'hBC,
    parameter int               LOCK_COUNT = 4,
    parameter int               MAX_GAP    = 16
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             com_det,
    output logic             locked
);

    localparam int CNT_MAX = (LOCK_COUNT > MAX_GAP) ? LOCK_COUNT : MAX_GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int BW      = $clog2(WIDTH);

    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [CW-1:0] COM_LAST = CW'(LOCK_COUNT - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'((MAX_GAP > 0) ? (MAX_GAP - 1) : 0);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    // The oldest bit of the shift window is never needed after the shift,
    // so only WIDTH-1 history bits are stored.
    logic [WIDTH-2:0] sr_q, sr_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]    com_cnt_q, com_cnt_d;
    logic [CW-1:0]    gap_cnt_q, gap_cnt_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             valid_out_q, valid_out_d;
    logic             com_det_q, com_det_d;
    logic             locked_q, locked_d;

    logic [WIDTH-1:0] nxt;
    logic             is_com;
    logic             boundary;

    always_comb begin
        nxt         = {sr_q, data_in};
        is_com      = (nxt == COM);
        boundary    = (bit_cnt_q == BIT_LAST);

        sr_d        = nxt[WIDTH-2:0];
        bit_cnt_d   = boundary ? '0 : bit_cnt_q + 1'b1;
        com_cnt_d   = com_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        com_det_d   = 1'b0;
        state_d     = state_q;

        case (state_q)
            HUNT: begin
                // Every edge is a candidate boundary; the counter is only
                // meaningful once a COM has fixed the word phase.
                bit_cnt_d = '0;
                if (is_com) begin
                    com_cnt_d = CW'(1);
                    com_det_d = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = (LOCK_COUNT == 1) ? LOCKED : SYNC;
                end
            end
            SYNC: begin
                if (boundary) begin
                    if (is_com) begin
                        com_det_d = 1'b1;
                        com_cnt_d = com_cnt_q + 1'b1;
                        if (com_cnt_q == COM_LAST) begin
                            state_d   = LOCKED;
                            gap_cnt_d = '0;
                        end
                    end else begin
                        // Misaligned guess: fall back and hunt from the next bit.
                        state_d   = HUNT;
                        com_cnt_d = '0;
                        bit_cnt_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (boundary) begin
                    if (is_com) begin
                        data_out_d = nxt;
                        com_det_d  = 1'b1;
                        gap_cnt_d  = '0;
                    end else if ((MAX_GAP != 0) && (gap_cnt_q == GAP_LAST)) begin
                        // Too long without a COM: the word that trips the
                        // limit is dropped rather than forwarded.
                        state_d   = HUNT;
                        com_cnt_d = '0;
                        gap_cnt_d = '0;
                        bit_cnt_d = '0;
                    end else begin
                        data_out_d  = nxt;
                        valid_out_d = 1'b1;
                        if (MAX_GAP != 0) begin
                            gap_cnt_d = gap_cnt_q + 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d   = HUNT;
                com_cnt_d = '0;
                gap_cnt_d = '0;
                bit_cnt_d = '0;
            end
        endcase

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state_q     <= HUNT;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            com_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            com_det_q   <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            com_cnt_q   <= com_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            com_det_q   <= com_det_d;
            locked_q    <= locked_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;
    assign com_det   = com_det_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_serial_parallel_aligner.sv
module tb_serial_parallel_aligner;

    localparam logic [7:0] COM_SYM = 8'hBC;

    logic       clk_32f;
    logic       reset;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       com_det;
    logic       locked;

    int n_compared;
    int n_mismatched;

    // Event counters accumulated by send_bit, sampled just after each edge.
    int vld_seen;
    int com_seen;
    int both_seen;

    serial_parallel_aligner #(
        .WIDTH      (8),
        .COM        (8'hBC),
        .LOCK_COUNT (4),
        .MAX_GAP    (16)
    ) dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .com_det   (com_det),
        .locked    (locked)
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    task automatic clear_counts();
        vld_seen = 0;
        com_seen = 0;
    endtask

    // Drive one bit away from the rising edge, then sample 1 time unit after it.
    task automatic send_bit(input logic b);
        @(negedge clk_32f);
        data_in = b;
        @(posedge clk_32f);
        #1;
        if (valid_out === 1'b1) vld_seen++;
        if (com_det === 1'b1) com_seen++;
        if (valid_out === 1'b1 && com_det === 1'b1) both_seen++;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic apply_reset();
        @(negedge clk_32f);
        data_in = 1'b0;
        reset   = 1'b0;
        repeat (2) @(negedge clk_32f);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        data_in = 1'b0;
        reset   = 1'b0;
        #23;
        n_compared++;
        if ({data_out, valid_out, com_det, locked} !== 11'd0) begin
            n_mismatched++;
            $display("FAIL reset_outputs: got data_out=%h valid=%b com=%b locked=%b, need all 0",
                     data_out, valid_out, com_det, locked);
        end
        @(negedge clk_32f);
        reset = 1'b1;
    endtask

    task automatic test_lock_and_data();
        apply_reset();
        clear_counts();
        for (int k = 0; k < 4; k++) begin
            send_word(COM_SYM);
            n_compared++;
            if (com_det !== 1'b1) begin
                n_mismatched++;
                $display("FAIL lock_com_pulse[%0d]: got com_det=%b, need 1", k, com_det);
            end
            if (k == 2) begin
                n_compared++;
                if (locked !== 1'b0) begin
                    n_mismatched++;
                    $display("FAIL lock_early: got locked=%b after 3 COMs, need 0", locked);
                end
            end
        end
        n_compared++;
        if (locked !== 1'b1) begin
            n_mismatched++;
            $display("FAIL lock_rise: got locked=%b after 4 COMs, need 1", locked);
        end
        send_word(8'h3A);
        n_compared++;
        if (valid_out !== 1'b1 || data_out !== 8'h3A) begin
            n_mismatched++;
            $display("FAIL lock_word0: got valid=%b data=%h, need 1 / 3a", valid_out, data_out);
        end
        send_word(8'hC5);
        n_compared++;
        if (valid_out !== 1'b1 || data_out !== 8'hC5) begin
            n_mismatched++;
            $display("FAIL lock_word1: got valid=%b data=%h, need 1 / c5", valid_out, data_out);
        end
        n_compared++;
        if (vld_seen != 2 || com_seen != 4) begin
            n_mismatched++;
            $display("FAIL lock_counts: got valid pulses=%0d com pulses=%0d, need 2 / 4",
                     vld_seen, com_seen);
        end
    endtask

    task automatic test_offset();
        apply_reset();
        clear_counts();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        repeat (4) send_word(COM_SYM);
        send_word(8'h55);
        n_compared++;
        if (valid_out !== 1'b1 || data_out !== 8'h55 || locked !== 1'b1) begin
            n_mismatched++;
            $display("FAIL offset_word: got valid=%b data=%h locked=%b, need 1 / 55 / 1",
                     valid_out, data_out, locked);
        end
        n_compared++;
        if (vld_seen != 1 || com_seen != 4) begin
            n_mismatched++;
            $display("FAIL offset_counts: got valid pulses=%0d com pulses=%0d, need 1 / 4",
                     vld_seen, com_seen);
        end
    endtask

    task automatic test_relock();
        apply_reset();
        clear_counts();
        repeat (3) send_word(COM_SYM);
        send_word(8'h12);
        n_compared++;
        if (locked !== 1'b0 || vld_seen != 0 || com_seen != 3) begin
            n_mismatched++;
            $display("FAIL relock_drop: got locked=%b valid pulses=%0d com pulses=%0d, need 0 / 0 / 3",
                     locked, vld_seen, com_seen);
        end
        repeat (4) send_word(COM_SYM);
        n_compared++;
        if (locked !== 1'b1) begin
            n_mismatched++;
            $display("FAIL relock_rise: got locked=%b, need 1", locked);
        end
        send_word(8'h77);
        n_compared++;
        if (valid_out !== 1'b1 || data_out !== 8'h77 || vld_seen != 1 || com_seen != 7) begin
            n_mismatched++;
            $display("FAIL relock_word: got valid=%b data=%h pulses v=%0d c=%0d, need 1 / 77 / 1 / 7",
                     valid_out, data_out, vld_seen, com_seen);
        end
    endtask

    task automatic test_gap_loss();
        logic [7:0] w;
        apply_reset();
        repeat (4) send_word(COM_SYM);
        clear_counts();
        for (int i = 1; i <= 15; i++) begin
            w = 8'(i);
            send_word(w);
            n_compared++;
            if (valid_out !== 1'b1 || data_out !== w || locked !== 1'b1) begin
                n_mismatched++;
                $display("FAIL gap_word[%0d]: got valid=%b data=%h locked=%b, need 1 / %h / 1",
                         i, valid_out, data_out, locked, w);
            end
        end
        send_word(8'h10);
        n_compared++;
        if (locked !== 1'b0 || valid_out !== 1'b0 || data_out !== 8'h0F) begin
            n_mismatched++;
            $display("FAIL gap_drop: got locked=%b valid=%b data=%h, need 0 / 0 / 0f",
                     locked, valid_out, data_out);
        end
        n_compared++;
        if (vld_seen != 15) begin
            n_mismatched++;
            $display("FAIL gap_count: got %0d valid pulses, need 15", vld_seen);
        end
    endtask

    task automatic test_long_stream();
        logic [7:0] w;
        int         n_data;
        int         n_unlocked;
        apply_reset();
        repeat (4) send_word(COM_SYM);
        clear_counts();
        n_data     = 0;
        n_unlocked = 0;
        for (int i = 0; i < 200; i++) begin
            if (i % 10 == 9) begin
                w = COM_SYM;
            end else begin
                w = 8'(i) & 8'h7F;
                n_data++;
            end
            send_word(w);
            if (locked !== 1'b1) n_unlocked++;
            if (w != COM_SYM) begin
                n_compared++;
                if (valid_out !== 1'b1 || data_out !== w) begin
                    n_mismatched++;
                    $display("FAIL long_word[%0d]: got valid=%b data=%h, need 1 / %h",
                             i, valid_out, data_out, w);
                end
            end
        end
        n_compared++;
        if (n_unlocked != 0) begin
            n_mismatched++;
            $display("FAIL long_locked: locked was low after %0d words, need 0", n_unlocked);
        end
        n_compared++;
        if (vld_seen != n_data || com_seen != 20) begin
            n_mismatched++;
            $display("FAIL long_counts: got valid=%0d com=%0d, need %0d / 20",
                     vld_seen, com_seen, n_data);
        end
    endtask

    task automatic test_reset_mid_lock();
        apply_reset();
        repeat (4) send_word(COM_SYM);
        send_word(8'h3A);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        #2;
        reset = 1'b0;
        #1;
        n_compared++;
        if ({data_out, valid_out, com_det, locked} !== 11'd0) begin
            n_mismatched++;
            $display("FAIL midreset_async: got data=%h valid=%b com=%b locked=%b, need all 0",
                     data_out, valid_out, com_det, locked);
        end
        repeat (3) @(posedge clk_32f);
        @(negedge clk_32f);
        data_in = 1'b0;
        reset   = 1'b1;
        clear_counts();
        repeat (3) send_word(COM_SYM);
        n_compared++;
        if (locked !== 1'b0 || com_seen != 3) begin
            n_mismatched++;
            $display("FAIL midreset_partial: got locked=%b com pulses=%0d, need 0 / 3",
                     locked, com_seen);
        end
        send_word(COM_SYM);
        n_compared++;
        if (locked !== 1'b1) begin
            n_mismatched++;
            $display("FAIL midreset_relock: got locked=%b after 4 COMs, need 1", locked);
        end
    endtask

    task automatic test_exclusive();
        n_compared++;
        if (both_seen != 0) begin
            n_mismatched++;
            $display("FAIL valid_com_overlap: saw %0d cycles with both high, need 0", both_seen);
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        both_seen    = 0;
        vld_seen     = 0;
        com_seen     = 0;
        data_in      = 1'b0;
        reset        = 1'b0;

        test_reset();
        test_lock_and_data();
        test_offset();
        test_relock();
        test_gap_loss();
        test_long_stream();
        test_reset_mid_lock();
        test_exclusive();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/serial_parallel_aligner.md
Name: serial_parallel_aligner

Overview:
Parametrised, single-clock successor to the PHY receive deserializer. Shifts a serial bit stream in MSB-first at bit rate and hunts for the COM symbol at any bit offset. It locks word alignment after LOCK_COUNT consecutive aligned COMs and then emits parallel words with a per-word valid strobe. Lock is dropped when COMs stop arriving. It sits between the serial lane input and the byte un-striping logic.

Parameters:
WIDTH, 8, symbol width in bits (≥4)
COM, 8'hBC, alignment symbol (WIDTH bits)
LOCK_COUNT, 4, consecutive aligned COMs required to lock (≥1)
MAX_GAP, 16, consecutive non-COM words tolerated while locked; the MAX_GAP-th drops lock; 0 disables loss detection

Ports:
clk_32f  input  1  bit-rate clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset
data_in  input  1  serial data, sampled every clk_32f rising edge, MSB of each word first
data_out  output  WIDTH  last completed word while locked; registered
valid_out  output  1  one-cycle pulse: data_out holds a new non-COM word
com_det  output  1  one-cycle pulse: an aligned COM was completed (any state)
locked  output  1  high in LOCKED state

Behaviour:
- Reset (reset=0, async): sr, bit_cnt, com_cnt, gap_cnt, data_out cleared to 0; valid_out, com_det, locked = 0; state = HUNT. Same when reset asserts mid-word or mid-lock; no partial word survives.
- Shift register: each edge, sr <= {sr[WIDTH-2:0], data_in}. Define nxt = {sr[WIDTH-2:0], data_in}.
- Boundary: in HUNT, every edge is a candidate. In SYNC/LOCKED, a boundary occurs when bit_cnt == WIDTH-1. bit_cnt then wraps to 0; otherwise it increments.
- HUNT: if nxt == COM, then bit_cnt <= 0, com_cnt <= 1, com_det pulses, and state goes to SYNC, or directly to LOCKED if LOCK_COUNT == 1. Otherwise hold.
- SYNC, at a boundary:
  - nxt == COM: com_det pulses, com_cnt++. When com_cnt reaches LOCK_COUNT, state goes to LOCKED and gap_cnt <= 0.
  - nxt != COM: state goes to HUNT and com_cnt <= 0. No realign is attempted on that same edge.
- LOCKED, at a boundary:
  - data_out <= nxt.
  - nxt == COM: com_det = 1, valid_out = 0, gap_cnt <= 0.
  - nxt != COM and (MAX_GAP == 0 or gap_cnt+1 < MAX_GAP): valid_out = 1, gap_cnt++.
  - nxt != COM and gap_cnt+1 == MAX_GAP: word discarded (data_out not updated, valid_out = 0). State goes to HUNT, locked drops at this edge, and com_cnt and gap_cnt clear.
- Latency: the last bit of a word, sampled at edge k, appears on data_out/valid_out/com_det immediately after edge k (1 register stage). valid_out and com_det are never high in the same cycle.
- Between boundaries, valid_out and com_det are 0 and data_out holds its value.
- locked is a registered copy of (state == LOCKED). In SYNC/HUNT, data_out holds its last value and valid_out = 0.
- A COM pattern at a non-boundary offset while LOCKED or SYNC is ignored; it is not a realign trigger.
- Counters are sized for clog2(max(LOCK_COUNT,MAX_GAP)+1). No wrap is possible because each counter is reset at its limit.

Test Plan:
- Reset, then serial stream of 4×8'hBC followed by 8'h3A, 8'hC5 MSB-first → com_det pulses 4 times, locked rises at the 4th COM boundary. valid_out pulses twice with data_out = 8'h3A, then 8'hC5, each 8 cycles apart, 1 cycle after the last bit.
- 3 junk bits, then 4×BC, then 8'h55 → alignment at offset 3, data_out = 8'h55, valid_out = 1 once.
- 3×BC, then 8'h12, then 4×BC, then 8'h77 → returns to HUNT after 8'h12 with no valid_out. Relocks on the second COM group, then outputs 8'h77.
- MAX_GAP = 16, locked, then 16 non-COM words 8'h01..8'h10 → valid_out for 8'h01..8'h0F (15 pulses). At the 16th boundary locked = 0, valid_out = 0, data_out stays 8'h0F.
- Locked stream with an inserted COM every 10 words → locked stays 1 for 200 words, and valid_out count equals the non-COM word count.
- Assert reset for 3 cycles in mid-word while locked → all outputs 0 asynchronously. After release, 4 COMs are needed to relock.
